logic_ops_pipe: RTL and testbench

- Parametrised, pipelined bitwise/logical operator unit; successor to the combinational 8-bit logic-op block.
- Adds generic width, an opcode-selected operation, a valid/ready handshake, configurable pipeline latency, and a folding accumulator mode.
- Sits between an operand producer and a result consumer. Also serves as a sequential frontend regression target.

---
 rtl/logic_ops_pipe.sv | 152 +++++++++++++++
 tb/tb_logic_ops_pipe.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_ops_pipe.sv
// -----------------------------------------------------------------------------
// logic_ops_pipe
//
// Pipelined bitwise / logical operator unit with an opcode-selected operation,
// a folding accumulator and a LATENCY-deep register pipeline.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   unit can accept a beat this cycle
//   op         opcode, sampled on accept
//   a, b       operands (WIDTH bits)
//   acc_first  on ACC_* ops, seed the accumulator with a instead of folding
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     operation result (WIDTH bits)
//   zero       result == 0, aligned with result
//
// Handshake: a beat transfers in on a clock edge where in_valid & in_ready,
// and a result transfers out on an edge where out_valid & out_ready. The
// whole pipeline moves together on advance = !out_valid | out_ready, and
// in_ready is exactly advance, so in_ready depends combinationally on
// out_ready (there is no skid buffer). While advance is low every stage
// holds, so result and zero stay stable while out_valid is high.
//
// Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a,
//          8 LAND, 9 LOR, 10 RED_AND, 11 RED_OR, 12 RED_XOR (bit0 only),
//          13 ACC_AND, 14 ACC_OR, 15 ACC_XOR (fold a into accumulator).
// -----------------------------------------------------------------------------
module logic_ops_pipe #(
   parameter int WIDTH   = 8,   // >= 2
   parameter int LATENCY = 2    // 1..4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam logic [3:0] OP_AND     = 4'd0;
   localparam logic [3:0] OP_OR      = 4'd1;
   localparam logic [3:0] OP_NAND    = 4'd2;
   localparam logic [3:0] OP_NOR     = 4'd3;
   localparam logic [3:0] OP_XOR     = 4'd4;
   localparam logic [3:0] OP_XNOR    = 4'd5;
   localparam logic [3:0] OP_NOT     = 4'd6;
   localparam logic [3:0] OP_BUF     = 4'd7;
   localparam logic [3:0] OP_LAND    = 4'd8;
   localparam logic [3:0] OP_LOR     = 4'd9;
   localparam logic [3:0] OP_RED_AND = 4'd10;
   localparam logic [3:0] OP_RED_OR  = 4'd11;
   localparam logic [3:0] OP_RED_XOR = 4'd12;
   localparam logic [3:0] OP_ACC_AND = 4'd13;
   localparam logic [3:0] OP_ACC_OR  = 4'd14;
   localparam logic [3:0] OP_ACC_XOR = 4'd15;

   // Pipeline stage registers; index LATENCY-1 drives the outputs.
   logic             vld_q [LATENCY];
   logic [WIDTH-1:0] dat_q [LATENCY];
   logic             zro_q [LATENCY];

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;

   logic             advance;
   logic             accept;
   logic [WIDTH-1:0] op_res;
   logic [WIDTH-1:0] fold_val;

   assign out_valid = vld_q[LATENCY-1];
   assign result    = dat_q[LATENCY-1];
   assign zero      = zro_q[LATENCY-1];

   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign accept    = in_valid && in_ready;

   // Operation and accumulator fold. The accumulator is updated at accept
   // time (not at output time) so consecutive ACC beats chain correctly no
   // matter how deep the pipeline is or how long it stalls.
   always_comb begin
      op_res   = '0;
      fold_val = a;
      acc_d    = acc_q;

      case (op)
         OP_ACC_AND: fold_val = acc_first ? a : (acc_q & a);
         OP_ACC_OR:  fold_val = acc_first ? a : (acc_q | a);
         OP_ACC_XOR: fold_val = acc_first ? a : (acc_q ^ a);
         default:    fold_val = a;
      endcase

      case (op)
         OP_AND:     op_res    = a & b;
         OP_OR:      op_res    = a | b;
         OP_NAND:    op_res    = ~(a & b);
         OP_NOR:     op_res    = ~(a | b);
         OP_XOR:     op_res    = a ^ b;
         OP_XNOR:    op_res    = ~(a ^ b);
         OP_NOT:     op_res    = ~a;
         OP_BUF:     op_res    = a;
         OP_LAND:    op_res[0] = (|a) && (|b);
         OP_LOR:     op_res[0] = (|a) || (|b);
         OP_RED_AND: op_res[0] = &a;
         OP_RED_OR:  op_res[0] = |a;
         OP_RED_XOR: op_res[0] = ^a;
         OP_ACC_AND,
         OP_ACC_OR,
         OP_ACC_XOR: begin
            op_res = fold_val;
            if (accept) begin
               acc_d = fold_val;
            end
         end
         default:    op_res    = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            vld_q[i] <= 1'b0;
            dat_q[i] <= '0;
            zro_q[i] <= 1'b0;
         end
      end else begin
         acc_q <= acc_d;
         if (advance) begin
            // Bubbles enter stage 0 as all-zero data with zero flag low.
            vld_q[0] <= accept;
            dat_q[0] <= accept ? op_res : '0;
            zro_q[0] <= accept && (op_res == '0);
            for (int i = 1; i < LATENCY; i++) begin
               vld_q[i] <= vld_q[i-1];
               dat_q[i] <= dat_q[i-1];
               zro_q[i] <= zro_q[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_logic_ops_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_ops_pipe
//
// Directed bench for logic_ops_pipe. The main instance is WIDTH=8/LATENCY=2;
// two WIDTH=16 instances (LATENCY=1 and LATENCY=4) share a second set of
// inputs. Inputs are driven just after the falling edge and outputs are
// sampled there as well, half a cycle away from the active edge.
// -----------------------------------------------------------------------------
module tb_logic_ops_pipe;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- main instance (8 bit, latency 2) ----------------
   logic       in_valid;
   logic       in_ready;
   logic [3:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       acc_first;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       zero;

   logic_ops_pipe #(.WIDTH(8), .LATENCY(2)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .acc_first (acc_first),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   // ---------------- 16-bit instances (latency 1 and 4) ----------------
   logic        w_in_valid;
   logic [3:0]  w_op;
   logic [15:0] w_a;
   logic [15:0] w_b;
   logic        l1_in_ready, l1_out_valid, l1_zero;
   logic [15:0] l1_result;
   logic        l4_in_ready, l4_out_valid, l4_zero;
   logic [15:0] l4_result;

   logic_ops_pipe #(.WIDTH(16), .LATENCY(1)) u_l1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_in_valid),
      .in_ready  (l1_in_ready),
      .op        (w_op),
      .a         (w_a),
      .b         (w_b),
      .acc_first (1'b0),
      .out_valid (l1_out_valid),
      .out_ready (1'b1),
      .result    (l1_result),
      .zero      (l1_zero)
   );

   logic_ops_pipe #(.WIDTH(16), .LATENCY(4)) u_l4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_in_valid),
      .in_ready  (l4_in_ready),
      .op        (w_op),
      .a         (w_a),
      .b         (w_b),
      .acc_first (1'b0),
      .out_valid (l4_out_valid),
      .out_ready (1'b1),
      .result    (l4_result),
      .zero      (l4_zero)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   // ---------------- driver tasks ----------------
   task automatic drive_beat(input logic [3:0] t_op, input logic [7:0] t_a,
                             input logic [7:0] t_b, input logic t_first);
      in_valid  = 1'b1;
      op        = t_op;
      a         = t_a;
      b         = t_b;
      acc_first = t_first;
   endtask

   task automatic drive_idle();
      in_valid  = 1'b0;
      op        = 4'd0;
      a         = 8'h00;
      b         = 8'h00;
      acc_first = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive_idle();
      w_in_valid = 1'b0;
      w_op = 4'd0;
      w_a  = 16'h0;
      w_b  = 16'h0;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: out_valid=%b result=%h zero=%b, required 0/00/0",
                  out_valid, result, zero);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_opcodes();
      logic [7:0] exp_tab [8];
      exp_tab = '{8'h24, 8'hBD, 8'hDB, 8'h42, 8'h99, 8'h66, 8'h5A, 8'hA5};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive_beat(4'(i), 8'hA5, 8'h3C, 1'b0);
         @(negedge clk);
         drive_idle();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL op%0d_early: out_valid=%b one edge after accept, required 0",
                     i, out_valid);
         end
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || result !== exp_tab[i] || zero !== 1'b0) begin
            errors++;
            $display("FAIL op%0d_result: out_valid=%b result=%h zero=%b, required 1/%h/0",
                     i, out_valid, result, zero, exp_tab[i]);
         end
      end
   endtask

   task automatic test_logical();
      logic [3:0] t_op [5];
      logic [7:0] t_a  [5];
      logic [7:0] t_b  [5];
      logic [7:0] t_e  [5];
      logic       t_z  [5];
      t_op = '{4'd8,  4'd9,  4'd10, 4'd12, 4'd11};
      t_a  = '{8'h10, 8'h10, 8'hFF, 8'h07, 8'h00};
      t_b  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      t_e  = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00};
      t_z  = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive_beat(t_op[i], t_a[i], t_b[i], 1'b0);
         @(negedge clk);
         drive_idle();
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || result !== t_e[i] || zero !== t_z[i]) begin
            errors++;
            $display("FAIL logical_op%0d: out_valid=%b result=%h zero=%b, required 1/%h/%b",
                     t_op[i], out_valid, result, zero, t_e[i], t_z[i]);
         end
      end
   endtask

   task automatic test_acc_chain();
      logic [3:0] t_op [4];
      logic [7:0] t_a  [4];
      logic       t_f  [4];
      logic [7:0] exp_v;
      t_op = '{4'd14, 4'd14, 4'd15, 4'd13};
      t_a  = '{8'h01, 8'h04, 8'h05, 8'hF0};
      t_f  = '{1'b1,  1'b0,  1'b0,  1'b1};
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h05);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hF0);
      // Beats go in back to back; results are popped as they come out.
      for (int cyc = 0; cyc < 7; cyc++) begin
         @(negedge clk);
         if (cyc >= 2 && cyc < 6) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || result !== exp_v || zero !== (exp_v == 8'h00)) begin
               errors++;
               $display("FAIL acc_chain_%0d: out_valid=%b result=%h zero=%b, required 1/%h/%b",
                        cyc - 2, out_valid, result, zero, exp_v, (exp_v == 8'h00));
            end
         end else begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL acc_chain_bubble_%0d: out_valid=%b, required 0", cyc, out_valid);
            end
         end
         if (cyc < 4) drive_beat(t_op[cyc], t_a[cyc], 8'hFF, t_f[cyc]);
         else drive_idle();
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_v;
      out_ready = 1'b1;
      @(negedge clk);
      drive_beat(4'd7, 8'h11, 8'h00, 1'b0);
      exp_q.push_back(8'h11);
      @(negedge clk);
      drive_beat(4'd7, 8'h22, 8'h00, 1'b0);
      exp_q.push_back(8'h22);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || result !== exp_v) begin
         errors++;
         $display("FAIL bp_first: out_valid=%b result=%h, required 1/%h", out_valid, result, exp_v);
      end
      drive_beat(4'd7, 8'h33, 8'h00, 1'b0);
      exp_q.push_back(8'h33);
      @(negedge clk);
      // Stall with the second result on the output and the fourth beat offered.
      out_ready = 1'b0;
      drive_beat(4'd7, 8'h44, 8'h00, 1'b0);
      exp_q.push_back(8'h44);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_in_ready_drop: in_ready=%b, required 0", in_ready);
      end
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || result !== exp_q[0] || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d: out_valid=%b result=%h in_ready=%b, required 1/%h/0",
                     s, out_valid, result, in_ready, exp_q[0]);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: in_ready=%b, required 1", in_ready);
      end
      void'(exp_q.pop_front());  // 0x22 transfers on the next edge
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive_idle();
         exp_v = exp_q.pop_front();
         checks++;
         if (out_valid !== 1'b1 || result !== exp_v) begin
            errors++;
            $display("FAIL bp_drain_%0d: out_valid=%b result=%h, required 1/%h",
                     k, out_valid, result, exp_v);
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_empty: out_valid=%b pending=%0d, required 0/0", out_valid, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      drive_beat(4'd14, 8'h5A, 8'h00, 1'b1);
      @(negedge clk);
      drive_beat(4'd7, 8'h77, 8'h00, 1'b0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 8'h5A) begin
         errors++;
         $display("FAIL rst_mid_pre: out_valid=%b result=%h, required 1/5a", out_valid, result);
      end
      drive_beat(4'd7, 8'h99, 8'h00, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async: out_valid=%b result=%h zero=%b, required 0/00/0",
                  out_valid, result, zero);
      end
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_flush: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
      end
      drive_beat(4'd7, 8'h33, 8'h00, 1'b0);
      @(negedge clk);
      drive_beat(4'd14, 8'h01, 8'h00, 1'b0);
      @(negedge clk);
      drive_idle();
      checks++;
      if (out_valid !== 1'b1 || result !== 8'h33) begin
         errors++;
         $display("FAIL rst_mid_buf: out_valid=%b result=%h, required 1/33", out_valid, result);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 8'h01) begin
         errors++;
         $display("FAIL rst_mid_acc: out_valid=%b result=%h, required 1/01", out_valid, result);
      end
      @(negedge clk);
   endtask

   task automatic test_width16();
      @(negedge clk);
      w_in_valid = 1'b1;
      w_op = 4'd4;
      w_a  = 16'hFFFF;
      w_b  = 16'h0F0F;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         w_in_valid = 1'b0;
         checks++;
         if (n == 1) begin
            if (l1_out_valid !== 1'b1 || l1_result !== 16'hF0F0 || l1_zero !== 1'b0) begin
               errors++;
               $display("FAIL w16_l1_result: out_valid=%b result=%h zero=%b, required 1/f0f0/0",
                        l1_out_valid, l1_result, l1_zero);
            end
         end else if (l1_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL w16_l1_extra_%0d: out_valid=%b, required 0", n, l1_out_valid);
         end
         checks++;
         if (n == 4) begin
            if (l4_out_valid !== 1'b1 || l4_result !== 16'hF0F0 || l4_zero !== 1'b0) begin
               errors++;
               $display("FAIL w16_l4_result: out_valid=%b result=%h zero=%b, required 1/f0f0/0",
                        l4_out_valid, l4_result, l4_zero);
            end
         end else if (l4_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL w16_l4_early_%0d: out_valid=%b, required 0", n, l4_out_valid);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_opcodes();
      test_logical();
      test_acc_chain();
      test_backpressure();
      test_reset_mid();
      test_width16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
